sda_kernel_ctrl_multi: RTL and testbench
========================================

SDA_KERNEL_CTRL_MULTI -- requirements
Module: sda_kernel_ctrl_multi

Interface
REQ-001 SHALL have parameter REG_ADDR_WIDTH, default 12: register bus address width.
REQ-002 SHALL have parameter NUM_CHANNELS, default 4, legal range 1..16: number of independent action channels.
REQ-003 SHALL have parameter BASE_ADDR, default 0: byte offset of the 32-byte register window.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have ports reg_req (in, 1), reg_write_en (in, 1), reg_addr (in, REG_ADDR_WIDTH), reg_wdata (in, 32), reg_wstrb (in, 4): register access request.
REQ-007 SHALL have ports reg_ack (out, 1) and reg_rdata (out, 32): access completion and OR-bus read data.
REQ-008 SHALL have ports go_Ready (out, NUM_CHANNELS) and go_Stop (in, NUM_CHANNELS): per-channel SELF go token.
REQ-009 SHALL have ports done_Ready (in, NUM_CHANNELS) and done_Stop (out, NUM_CHANNELS): per-channel SELF done token.
REQ-010 SHALL have port interrupt, output, 1 bit: level interrupt.

Function
REQ-011 SHALL decode word offsets relative to BASE_ADDR: 0x00 CTRL, 0x04 GIE, 0x08 IER, 0x0C ISR, 0x10 CHAN_MASK, 0x14 CHAN_BUSY (RO); 0x18 and 0x1C read 0 and ignore writes.
REQ-012 SHALL assert reg_ack for exactly one cycle, the cycle after reg_req is sampled high with an address inside the window; out-of-window requests get no ack.
REQ-013 SHALL drive reg_rdata with read data only in the reg_ack cycle of a read; it is zero in all other cycles.
REQ-014 SHALL apply writes per byte lane, updating only bytes whose reg_wstrb bit is 1; bits above NUM_CHANNELS-1 read 0.
REQ-015 CTRL SHALL have these bits: bit0 ap_start (W1S; reads 1 while any channel is not IDLE); bit1 ap_done (set on batch completion, cleared by a CTRL read); bit2 ap_idle (1 when all channels are IDLE); bit7 auto_restart (RW).
REQ-016 Writing ap_start=1 while ap_idle=1 SHALL launch every channel whose CHAN_MASK bit is 1; the write SHALL be ignored when ap_idle=0 or CHAN_MASK=0.
REQ-017 Each channel SHALL run its own FSM: IDLE -> GO on launch; GO -> RUN on the cycle go_Ready=1 and go_Stop=0; RUN -> IDLE on the cycle done_Ready=1 and done_Stop=0.
REQ-018 go_Ready SHALL be 1 only in GO, and done_Stop SHALL be 0 only in RUN; both are registered outputs.
REQ-019 On a RUN->IDLE transition, the channel's ISR bit SHALL be set; when set and a W1C write to that bit occur in the same cycle, set SHALL win.
REQ-020 When the last launched channel returns to IDLE, ap_done SHALL be set in the same cycle. If auto_restart=1, the same CHAN_MASK SHALL be relaunched on the next cycle, and ap_done remains set until read.
REQ-021 interrupt SHALL be registered: GIE[0] AND OR-reduce(ISR AND IER), updating one cycle after the change.
REQ-022 CHAN_MASK writes SHALL take effect only for the next launch; running channels are unaffected.

Reset
REQ-023 While reset=1, every channel SHALL be forced to IDLE, and the outputs SHALL be: go_Ready=0, done_Stop=all ones, reg_ack=0, reg_rdata=0, interrupt=0.
REQ-024 Register reset values SHALL be: CTRL=0x4, GIE=0, IER=0, ISR=0, CHAN_MASK=all ones. Reset asserted mid-operation SHALL abandon in-flight tokens without setting ISR.

Verification
REQ-025 Launch and complete: CHAN_MASK=0x3; write CTRL=0x1; hold go_Stop=0 and pulse done_Ready on ch0 then ch1 -> go_Ready=0x3 for one cycle, ISR=0x3, CTRL read=0x6, second read=0x4.
REQ-026 Back-pressure: hold go_Stop[0]=1 for 5 cycles -> go_Ready[0] stays 1 throughout; RUN is entered the cycle after go_Stop falls; ap_start reads 1 throughout.
REQ-027 Interrupt: GIE=1, IER=0x1, ch0 completes -> interrupt=1 one cycle later; write ISR=0x1 -> interrupt=0 one cycle later; a W1C coincident with completion leaves ISR=1.
REQ-028 Auto-restart: CTRL=0x81, CHAN_MASK=0x1, three done handshakes -> three GO phases, each starting one cycle after the preceding done.
REQ-029 Bus corner cases: a write to BASE_ADDR+0x40 gets no ack; a CHAN_MASK write with wstrb=0x2 changes only bits 15:8; ap_start written while busy leaves the FSMs unchanged.
REQ-030 Reset mid-RUN: assert reset with ch0 in RUN -> go_Ready=0, done_Stop=all ones, ISR=0, CTRL=0x4 immediately (asynchronous).

Source files
------------

// File: rtl/sda_kernel_ctrl_multi.sv
// Multi-channel kernel controller: a 32-byte register window that launches per-channel
// go/done token FSMs as one batch, with completion status, auto-restart and a level interrupt.
module sda_kernel_ctrl_multi #(
  parameter int REG_ADDR_WIDTH = 12,
  parameter int NUM_CHANNELS   = 4,
  parameter int BASE_ADDR      = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      reg_req,
  input  logic                      reg_write_en,
  input  logic [REG_ADDR_WIDTH-1:0] reg_addr,
  input  logic [31:0]               reg_wdata,
  input  logic [3:0]                reg_wstrb,
  output logic                      reg_ack,
  output logic [31:0]               reg_rdata,
  output logic [NUM_CHANNELS-1:0]   go_Ready,
  input  logic [NUM_CHANNELS-1:0]   go_Stop,
  input  logic [NUM_CHANNELS-1:0]   done_Ready,
  output logic [NUM_CHANNELS-1:0]   done_Stop,
  output logic                      interrupt
);

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_GO,
    CH_RUN
  } ch_state_t;

  logic [31:0] addr_ext;
  logic [31:0] offset;
  logic        in_window;
  logic [2:0]  word_sel;
  logic        wr, rd;
  logic        wr_ctrl, wr_gie, wr_ier, wr_isr, wr_mask, rd_ctrl;

  logic                    auto_restart_reg;
  logic                    ap_done_reg;
  logic                    gie_reg;
  logic [NUM_CHANNELS-1:0] ier_reg;
  logic [NUM_CHANNELS-1:0] isr_reg;
  logic [NUM_CHANNELS-1:0] chan_mask_reg;
  logic [NUM_CHANNELS-1:0] ier_next, isr_next, chan_mask_next;

  logic [NUM_CHANNELS-1:0] busy;
  logic [NUM_CHANNELS-1:0] completing;
  logic [NUM_CHANNELS-1:0] lane_wmask;
  logic [NUM_CHANNELS-1:0] wdata_ch;
  logic [NUM_CHANNELS-1:0] w1c_mask;
  logic [NUM_CHANNELS-1:0] launch_vec;
  logic                    ap_idle;
  logic                    batch_done;
  logic                    launch;
  logic                    restart;
  logic [31:0]             read_data;
  logic                    unused_ok;

  // Address decode: window is 32 bytes starting at BASE_ADDR.
  assign addr_ext  = 32'(reg_addr);
  assign offset    = addr_ext - 32'(BASE_ADDR);
  assign in_window = (addr_ext >= 32'(BASE_ADDR)) && (offset[31:5] == '0);
  assign word_sel  = offset[4:2];
  assign wr        = reg_req && reg_write_en && in_window;
  assign rd        = reg_req && !reg_write_en && in_window;
  assign wr_ctrl   = wr && (word_sel == 3'd0);
  assign wr_gie    = wr && (word_sel == 3'd1);
  assign wr_ier    = wr && (word_sel == 3'd2);
  assign wr_isr    = wr && (word_sel == 3'd3);
  assign wr_mask   = wr && (word_sel == 3'd4);
  assign rd_ctrl   = rd && (word_sel == 3'd0);
  assign wdata_ch  = reg_wdata[NUM_CHANNELS-1:0];
  assign unused_ok = &{1'b0, offset[1:0], reg_wdata, reg_wstrb};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
      ch_state_t state_reg, state_next;
      logic      go_ready_reg;
      logic      done_stop_reg;

      always_comb begin
        state_next = state_reg;
        case (state_reg)
          CH_IDLE: if (launch_vec[gi]) state_next = CH_GO;
          CH_GO:   if (!go_Stop[gi]) state_next = CH_RUN;
          // A completing channel may be relaunched straight away by auto-restart.
          CH_RUN:  if (done_Ready[gi]) state_next = launch_vec[gi] ? CH_GO : CH_IDLE;
          default: state_next = CH_IDLE;
        endcase
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_reg     <= CH_IDLE;
          go_ready_reg  <= 1'b0;
          done_stop_reg <= 1'b1;
        end else begin
          state_reg     <= state_next;
          go_ready_reg  <= (state_next == CH_GO);
          done_stop_reg <= (state_next != CH_RUN);
        end
      end

      assign busy[gi]       = (state_reg != CH_IDLE);
      assign completing[gi] = (state_reg == CH_RUN) && done_Ready[gi];
      assign go_Ready[gi]   = go_ready_reg;
      assign done_Stop[gi]  = done_stop_reg;
      assign lane_wmask[gi] = reg_wstrb[gi/8];
    end
  endgenerate

  assign ap_idle    = ~|busy;
  // The batch ends when every busy channel is finishing in this same cycle.
  assign batch_done = (|completing) && ((busy & ~completing) == '0);
  assign launch     = wr_ctrl && reg_wstrb[0] && reg_wdata[0] && ap_idle && (|chan_mask_reg);
  assign restart    = batch_done && auto_restart_reg;
  assign launch_vec = (launch || restart) ? chan_mask_reg : '0;

  assign ier_next       = (ier_reg & ~lane_wmask) | (wdata_ch & lane_wmask);
  assign chan_mask_next = (chan_mask_reg & ~lane_wmask) | (wdata_ch & lane_wmask);
  assign w1c_mask       = wr_isr ? (wdata_ch & lane_wmask) : '0;
  assign isr_next       = (isr_reg & ~w1c_mask) | completing;

  always_comb begin
    read_data = 32'd0;
    case (word_sel)
      3'd0: read_data = {24'd0, auto_restart_reg, 4'd0, ap_idle, ap_done_reg, !ap_idle};
      3'd1: read_data = {31'd0, gie_reg};
      3'd2: read_data = 32'(ier_reg);
      3'd3: read_data = 32'(isr_reg);
      3'd4: read_data = 32'(chan_mask_reg);
      3'd5: read_data = 32'(busy);
      default: read_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_ack          <= 1'b0;
      reg_rdata        <= 32'd0;
      auto_restart_reg <= 1'b0;
      ap_done_reg      <= 1'b0;
      gie_reg          <= 1'b0;
      ier_reg          <= '0;
      isr_reg          <= '0;
      chan_mask_reg    <= '1;
      interrupt        <= 1'b0;
    end else begin
      reg_ack   <= reg_req && in_window;
      reg_rdata <= rd ? read_data : 32'd0;
      if (wr_ctrl && reg_wstrb[0]) auto_restart_reg <= reg_wdata[7];
      // Completion beats a simultaneous CTRL read so a done event is never lost.
      if (batch_done)   ap_done_reg <= 1'b1;
      else if (rd_ctrl) ap_done_reg <= 1'b0;
      if (wr_gie && reg_wstrb[0]) gie_reg <= reg_wdata[0];
      if (wr_ier)  ier_reg <= ier_next;
      if (wr_mask) chan_mask_reg <= chan_mask_next;
      isr_reg   <= isr_next;
      interrupt <= gie_reg && (|(isr_reg & ier_reg));
    end
  end

endmodule

// File: tb/tb_sda_kernel_ctrl_multi.sv
// Directed bench for sda_kernel_ctrl_multi: 16 channels, register window at 0x100.
module tb_sda_kernel_ctrl_multi;

  localparam int AW = 12;
  localparam int NC = 16;
  localparam logic [AW-1:0] A_CTRL = 12'h100;
  localparam logic [AW-1:0] A_GIE  = 12'h104;
  localparam logic [AW-1:0] A_IER  = 12'h108;
  localparam logic [AW-1:0] A_ISR  = 12'h10C;
  localparam logic [AW-1:0] A_MASK = 12'h110;
  localparam logic [AW-1:0] A_BUSY = 12'h114;
  localparam logic [AW-1:0] A_RSV  = 12'h118;
  localparam logic [AW-1:0] A_OUT  = 12'h140;
  localparam logic [AW-1:0] A_LOW  = 12'h0FC;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          reg_req = 1'b0;
  logic          reg_write_en = 1'b0;
  logic [AW-1:0] reg_addr = '0;
  logic [31:0]   reg_wdata = '0;
  logic [3:0]    reg_wstrb = '0;
  logic          reg_ack;
  logic [31:0]   reg_rdata;
  logic [NC-1:0] go_Ready;
  logic [NC-1:0] go_Stop = '0;
  logic [NC-1:0] done_Ready = '0;
  logic [NC-1:0] done_Stop;
  logic          interrupt;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd_val;

  sda_kernel_ctrl_multi #(
    .REG_ADDR_WIDTH(AW),
    .NUM_CHANNELS  (NC),
    .BASE_ADDR     ('h100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .reg_req     (reg_req),
    .reg_write_en(reg_write_en),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_wstrb   (reg_wstrb),
    .reg_ack     (reg_ack),
    .reg_rdata   (reg_rdata),
    .go_Ready    (go_Ready),
    .go_Stop     (go_Stop),
    .done_Ready  (done_Ready),
    .done_Stop   (done_Stop),
    .interrupt   (interrupt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus tasks start at a falling edge and return at the next falling edge.
  task automatic bus_write(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic exp_ack);
    reg_req = 1'b1; reg_write_en = 1'b1; reg_addr = addr; reg_wdata = data; reg_wstrb = strb;
    @(negedge clk);
    chk($sformatf("wr_ack@%h", addr), 32'(reg_ack), 32'(exp_ack));
    reg_req = 1'b0; reg_write_en = 1'b0; reg_wdata = '0; reg_wstrb = '0;
  endtask

  task automatic bus_read(input logic [AW-1:0] addr, input logic exp_ack, output logic [31:0] data);
    reg_req = 1'b1; reg_write_en = 1'b0; reg_addr = addr;
    @(negedge clk);
    chk($sformatf("rd_ack@%h", addr), 32'(reg_ack), 32'(exp_ack));
    data = reg_rdata;
    reg_req = 1'b0;
  endtask

  task automatic pulse_done(input logic [NC-1:0] chans);
    done_Ready = chans;
    @(negedge clk);
    done_Ready = '0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_go_ready", 32'(go_Ready), 32'h0);
    chk("rst_done_stop", 32'(done_Stop), 32'hFFFF);
    chk("rst_ack", 32'(reg_ack), 32'h0);
    chk("rst_rdata", reg_rdata, 32'h0);
    chk("rst_irq", 32'(interrupt), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    bus_read(A_CTRL, 1'b1, rd_val); chk("rst_ctrl", rd_val, 32'h4);
    bus_read(A_MASK, 1'b1, rd_val); chk("rst_mask", rd_val, 32'hFFFF);
    bus_read(A_GIE, 1'b1, rd_val);  chk("rst_gie", rd_val, 32'h0);
    bus_read(A_IER, 1'b1, rd_val);  chk("rst_ier", rd_val, 32'h0);
    bus_read(A_ISR, 1'b1, rd_val);  chk("rst_isr", rd_val, 32'h0);
    chk("idle_rdata_zero", reg_rdata, 32'h0);

    // Launch and complete two channels
    bus_write(A_MASK, 32'h3, 4'hF, 1'b1);
    bus_write(A_CTRL, 32'h1, 4'h1, 1'b1);
    chk("launch_go_ready", 32'(go_Ready), 32'h3);
    chk("launch_done_stop", 32'(done_Stop), 32'hFFFF);
    @(negedge clk);
    chk("run_go_ready", 32'(go_Ready), 32'h0);
    chk("run_done_stop", 32'(done_Stop), 32'hFFFC);
    bus_read(A_CTRL, 1'b1, rd_val); chk("busy_ctrl", rd_val, 32'h1);
    bus_read(A_BUSY, 1'b1, rd_val); chk("busy_chan", rd_val, 32'h3);
    pulse_done(16'h1);
    chk("ch0_done_stop", 32'(done_Stop), 32'hFFFD);
    pulse_done(16'h2);
    chk("ch1_done_stop", 32'(done_Stop), 32'hFFFF);
    bus_read(A_ISR, 1'b1, rd_val);  chk("batch_isr", rd_val, 32'h3);
    bus_read(A_CTRL, 1'b1, rd_val); chk("batch_ctrl1", rd_val, 32'h6);
    bus_read(A_CTRL, 1'b1, rd_val); chk("batch_ctrl2", rd_val, 32'h4);

    // Back-pressure on go, then ignored ap_start and mask change while busy
    bus_write(A_MASK, 32'h1, 4'hF, 1'b1);
    go_Stop = 16'h1;
    bus_write(A_CTRL, 32'h1, 4'h1, 1'b1);
    chk("bp_go_1", 32'(go_Ready), 32'h1);
    bus_read(A_CTRL, 1'b1, rd_val); chk("bp_ctrl", rd_val, 32'h1);
    chk("bp_go_2", 32'(go_Ready), 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_go_hold%0d", i), 32'(go_Ready), 32'h1);
    end
    go_Stop = '0;
    @(negedge clk);
    chk("bp_run_go", 32'(go_Ready), 32'h0);
    chk("bp_run_done_stop", 32'(done_Stop), 32'hFFFE);
    bus_write(A_MASK, 32'h3, 4'hF, 1'b1);
    bus_write(A_CTRL, 32'h1, 4'h1, 1'b1);
    chk("busy_start_ignored", 32'(go_Ready), 32'h0);
    bus_read(A_BUSY, 1'b1, rd_val); chk("busy_start_chan", rd_val, 32'h1);
    pulse_done(16'h1);
    bus_read(A_CTRL, 1'b1, rd_val); chk("bp_ctrl_done", rd_val, 32'h6);
    bus_read(A_CTRL, 1'b1, rd_val); chk("bp_ctrl_clr", rd_val, 32'h4);
    bus_write(A_ISR, 32'hFFFF_FFFF, 4'hF, 1'b1);
    bus_read(A_ISR, 1'b1, rd_val);  chk("isr_w1c", rd_val, 32'h0);

    // Interrupt path
    bus_write(A_GIE, 32'h1, 4'hF, 1'b1);
    bus_write(A_IER, 32'h1, 4'hF, 1'b1);
    bus_write(A_MASK, 32'h1, 4'hF, 1'b1);
    bus_write(A_CTRL, 32'h1, 4'h1, 1'b1);
    @(negedge clk);
    pulse_done(16'h1);
    chk("irq_lag", 32'(interrupt), 32'h0);
    @(negedge clk);
    chk("irq_set", 32'(interrupt), 32'h1);
    bus_write(A_ISR, 32'h1, 4'hF, 1'b1);
    chk("irq_clr_lag", 32'(interrupt), 32'h1);
    @(negedge clk);
    chk("irq_clr", 32'(interrupt), 32'h0);
    bus_read(A_CTRL, 1'b1, rd_val); chk("irq_ctrl", rd_val, 32'h6);
    bus_write(A_CTRL, 32'h1, 4'h1, 1'b1);
    @(negedge clk);
    done_Ready = 16'h1;
    bus_write(A_ISR, 32'h1, 4'hF, 1'b1);
    done_Ready = '0;
    bus_read(A_ISR, 1'b1, rd_val);  chk("isr_set_wins", rd_val, 32'h1);
    bus_write(A_ISR, 32'h1, 4'hF, 1'b1);
    bus_read(A_CTRL, 1'b1, rd_val); chk("coinc_ctrl", rd_val, 32'h6);

    // Auto-restart: relaunch the cycle after each done
    bus_write(A_CTRL, 32'h81, 4'h1, 1'b1);
    chk("ar_go_0", 32'(go_Ready), 32'h1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("ar_run_%0d", k), 32'(go_Ready), 32'h0);
      pulse_done(16'h1);
      chk($sformatf("ar_go_%0d", k + 1), 32'(go_Ready), 32'h1);
    end
    @(negedge clk);
    bus_write(A_CTRL, 32'h0, 4'h1, 1'b1);
    pulse_done(16'h1);
    chk("ar_stop_go", 32'(go_Ready), 32'h0);
    bus_read(A_CTRL, 1'b1, rd_val); chk("ar_ctrl_done", rd_val, 32'h6);
    bus_read(A_CTRL, 1'b1, rd_val); chk("ar_ctrl_clr", rd_val, 32'h4);

    // Bus corner cases
    bus_write(A_OUT, 32'h1, 4'hF, 1'b0);
    bus_read(A_LOW, 1'b0, rd_val);  chk("below_rdata", rd_val, 32'h0);
    bus_write(A_RSV, 32'hFFFF_FFFF, 4'hF, 1'b1);
    bus_read(A_RSV, 1'b1, rd_val);  chk("rsv_read", rd_val, 32'h0);
    bus_write(A_IER, 32'hFFFF_FFFF, 4'hF, 1'b1);
    bus_read(A_IER, 1'b1, rd_val);  chk("ier_width", rd_val, 32'hFFFF);
    bus_write(A_MASK, 32'h1234_A5FE, 4'h2, 1'b1);
    bus_read(A_MASK, 1'b1, rd_val); chk("mask_lane1", rd_val, 32'hA501);
    bus_write(A_MASK, 32'h1, 4'hF, 1'b1);

    // Reset while channel 0 is running with ISR pending
    bus_write(A_CTRL, 32'h1, 4'h1, 1'b1);
    @(negedge clk);
    chk("pre_rst_done_stop", 32'(done_Stop), 32'hFFFE);
    pulse_done(16'h0);
    bus_write(A_ISR, 32'h0, 4'hF, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("arst_go_ready", 32'(go_Ready), 32'h0);
    chk("arst_done_stop", 32'(done_Stop), 32'hFFFF);
    chk("arst_irq", 32'(interrupt), 32'h0);
    chk("arst_ack", 32'(reg_ack), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus_read(A_ISR, 1'b1, rd_val);  chk("arst_isr", rd_val, 32'h0);
    bus_read(A_CTRL, 1'b1, rd_val); chk("arst_ctrl", rd_val, 32'h4);
    bus_read(A_MASK, 1'b1, rd_val); chk("arst_mask", rd_val, 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
